exit_park_ctrl: RTL and testbench

//  Parametrised, clocked exit controller for the parking lot. Decrypts an exit token

---
 rtl/exit_park_pkg.sv | 12 +
 rtl/park_timer.sv | 18 +
 rtl/exit_park_ctrl.sv | 110 +++++++++++
 tb/tb_exit_park_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exit_park_pkg.sv
// exit_park_pkg: shared state encoding, default parameters and token decryption
package exit_park_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, OPEN, LOCK} state_t;
  localparam int DEF_SLOTS       = 8;
  localparam int DEF_IDX_W       = 3;
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 16;
  localparam int DEF_GATE_CYCLES = 8;
  function automatic logic [5:0] decrypt_idx(input logic [5:0] token, input logic [5:0] pattern);
    return token ^ pattern;
  endfunction
endpackage

// File: rtl/park_timer.sv
// park_timer: loadable down-counter, done when it reaches zero
module park_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] count;
  assign done = count == '0;
  // load takes priority; otherwise count down and hold at zero
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (!done) count <= count - 1'b1;
endmodule

// File: rtl/exit_park_ctrl.sv
// exit_park_ctrl: token-checked exit gate with slot occupancy tracking and lockout
module exit_park_ctrl
  import exit_park_pkg::*;
#(
  parameter int SLOTS       = DEF_SLOTS,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             park_set,
  input  logic [IDX_W-1:0] park_set_idx,
  input  logic             exit_req,
  input  logic [IDX_W-1:0] token,
  input  logic [IDX_W-1:0] pattern,
  output logic [SLOTS-1:0] park_location,
  output logic [IDX_W:0]   free_count,
  output logic             exit_ack,
  output logic             exit_err,
  output logic             gate_open,
  output logic             locked
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int CMAX = LOCK_CYCLES > GATE_CYCLES ? LOCK_CYCLES : GATE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  state_t           state;
  logic [IDX_W-1:0] idx, idx_q;
  logic             valid, valid_q;
  logic [TW-1:0]    tries;
  logic [SLOTS-1:0] next_loc;
  logic [IDX_W:0]   next_free;
  logic             last_try, tmr_load, tmr_done;
  logic [CW-1:0]    tmr_val;
  // decrypt, validate against current occupancy, and form next occupancy (clear beats set)
  always_comb begin
    idx = IDX_W'(decrypt_idx(6'(token), 6'(pattern)));
    valid = 1'b0;
    next_free = (IDX_W+1)'(SLOTS);
    for (int i = 0; i < SLOTS; i++) begin
      valid = valid | (park_location[i] && idx == IDX_W'(i));
      next_loc[i] = (park_location[i] | (park_set && park_set_idx == IDX_W'(i)))
                    & ~(state == CHECK && valid_q && idx_q == IDX_W'(i));
      next_free = next_free - (IDX_W+1)'(next_loc[i]);
    end
    last_try = tries == TW'(MAX_TRIES - 1);
    tmr_load = state == CHECK && (valid_q || last_try);
    tmr_val = valid_q ? CW'(GATE_CYCLES - 1) : CW'(LOCK_CYCLES - 1);
  end
  park_timer #(.W(CW)) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .value(tmr_val),
    .done (tmr_done)
  );
  // exit FSM with registered pulses, gate/lock drives and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx_q <= '0;
      valid_q <= 1'b0;
      tries <= '0;
      park_location <= '0;
      free_count <= (IDX_W+1)'(SLOTS);
      exit_ack <= 1'b0;
      exit_err <= 1'b0;
      gate_open <= 1'b0;
      locked <= 1'b0;
    end else begin
      park_location <= next_loc;
      free_count <= next_free;
      exit_ack <= 1'b0;
      exit_err <= 1'b0;
      case (state)
        IDLE:
          if (exit_req) begin
            idx_q <= idx;
            valid_q <= valid;
            exit_ack <= valid;
            exit_err <= !valid;
            state <= CHECK;
          end
        CHECK:
          if (valid_q) begin
            tries <= '0;
            gate_open <= 1'b1;
            state <= OPEN;
          end else if (last_try) begin
            tries <= '0;
            locked <= 1'b1;
            state <= LOCK;
          end else begin
            tries <= tries + TW'(1);
            state <= IDLE;
          end
        OPEN:
          if (tmr_done) begin
            gate_open <= 1'b0;
            state <= IDLE;
          end
        default:
          if (tmr_done) begin
            locked <= 1'b0;
            state <= IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_exit_park_ctrl.sv
// tb_exit_park_ctrl: directed and random checks against a window-based exit model
module tb_exit_park_ctrl;
  localparam int S = 8, W = 3, MT = 3, LC = 16, GC = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic park_set = 1'b0, exit_req = 1'b0;
  logic [W-1:0] park_set_idx = '0, token = '0, pattern = '0;
  logic [S-1:0] park_location;
  logic [W:0] free_count;
  logic exit_ack, exit_err, gate_open, locked;
  logic ps6 = 1'b0, req6 = 1'b0;
  logic [2:0] psi6 = '0, tok6 = '0, pat6 = '0;
  logic [5:0] loc6;
  logic [3:0] free6;
  logic ack6, err6, gate6, locked6;
  int n_checks = 0, n_fail = 0;
  int e = 0;
  bit m_occ[S];
  int m_tries, m_ready, m_gf, m_gt, m_lf, m_lt, m_clr_e, m_clr_i;
  bit m_ack, m_err;

  always #5 clk = ~clk;

  exit_park_ctrl #(.SLOTS(S), .IDX_W(W), .MAX_TRIES(MT), .LOCK_CYCLES(LC), .GATE_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .park_set(park_set), .park_set_idx(park_set_idx),
    .exit_req(exit_req), .token(token), .pattern(pattern), .park_location(park_location),
    .free_count(free_count), .exit_ack(exit_ack), .exit_err(exit_err),
    .gate_open(gate_open), .locked(locked)
  );

  exit_park_ctrl #(.SLOTS(6), .IDX_W(3), .MAX_TRIES(MT), .LOCK_CYCLES(LC), .GATE_CYCLES(GC)) dut6 (
    .clk(clk), .reset(reset), .park_set(ps6), .park_set_idx(psi6),
    .exit_req(req6), .token(tok6), .pattern(pat6), .park_location(loc6),
    .free_count(free6), .exit_ack(ack6), .exit_err(err6),
    .gate_open(gate6), .locked(locked6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = '{default: 1'b0};
    m_tries = 0; m_ready = 0; m_clr_e = -1; m_clr_i = 0;
    m_gf = -1; m_gt = -2; m_lf = -1; m_lt = -2;
    m_ack = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int i;
    bit v;
    bit nxt[S];
    e++;
    i = int'(token ^ pattern);
    v = i < S && m_occ[i];
    nxt = m_occ;
    if (park_set && int'(park_set_idx) < S) nxt[park_set_idx] = 1'b1;
    if (m_clr_e == e) nxt[m_clr_i] = 1'b0;
    m_ack = 1'b0;
    m_err = 1'b0;
    if (exit_req && e >= m_ready) begin
      m_ack = v;
      m_err = !v;
      if (v) begin
        m_clr_e = e + 1; m_clr_i = i;
        m_gf = e + 1; m_gt = e + GC; m_ready = e + GC + 2;
        m_tries = 0;
      end else begin
        m_tries++;
        if (m_tries == MT) begin
          m_tries = 0;
          m_lf = e + 1; m_lt = e + LC; m_ready = e + LC + 2;
        end else m_ready = e + 2;
      end
    end
    m_occ = nxt;
  endtask

  task automatic check_all();
    logic [S-1:0] el;
    int fc;
    fc = S;
    for (int i = 0; i < S; i++) begin
      el[i] = m_occ[i];
      fc -= int'(m_occ[i]);
    end
    chk("loc", park_location, el);
    chk("free", free_count, fc);
    chk("ack", exit_ack, m_ack);
    chk("err", exit_err, m_err);
    chk("gate", gate_open, m_gf <= e && e <= m_gt);
    chk("locked", locked, m_lf <= e && e <= m_lt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
    exit_req = 1'b0; park_set = 1'b0; req6 = 1'b0; ps6 = 1'b0;
  endtask

  task automatic req(input logic [W-1:0] t, input logic [W-1:0] p);
    token = t; pattern = p; exit_req = 1'b1;
    tick();
  endtask

  task automatic park(input int i);
    park_set_idx = W'(i); park_set = 1'b1;
    tick();
  endtask

  initial begin
    int g, lk;
    model_reset();
    tick();
    tick();
    chk("rst_free", free_count, 8);
    chk("rst_loc", park_location, 0);
    @(negedge clk);
    reset = 1'b0;
    // 1: park slot 5, exit with token 110 / pattern 011
    park(5);
    chk("t1_set5", park_location[5], 1);
    req(3'b110, 3'b011);
    chk("t1_ack", exit_ack, 1);
    g = 0;
    repeat (12) begin
      tick();
      g += int'(gate_open);
    end
    chk("t1_gate_len", g, 8);
    chk("t1_bit5", park_location[5], 0);
    chk("t1_free", free_count, 8);
    // 2: three bad tokens lock the gate; requests during lock are ignored
    repeat (3) begin
      req(3'd2, 3'd0);
      chk("t2_err", exit_err, 1);
      tick();
    end
    chk("t2_locked", locked, 1);
    lk = 1;
    park(6);
    lk += int'(locked);
    for (int i = 0; i < 20; i++) begin
      if (i < 10) begin
        exit_req = 1'b1; token = 3'd6; pattern = 3'd0;
      end
      tick();
      lk += int'(locked);
      chk("t2_no_ack", exit_ack, 0);
    end
    chk("t2_lock_len", lk, 16);
    chk("t2_bit6", park_location[6], 1);
    // 3: two bad then good clears tries; two further bad do not lock
    req(3'd2, 3'd0); tick();
    req(3'd2, 3'd0); tick();
    req(3'd6, 3'd0);
    chk("t3_ack", exit_ack, 1);
    repeat (10) tick();
    req(3'd2, 3'd0); tick();
    req(3'd2, 3'd0); tick();
    chk("t3_nolock", locked, 0);
    // 4: park_set racing the clear of the same slot, then of another slot
    park(4);
    req(3'd4, 3'd0);
    park(4);
    chk("t4_bit4", park_location[4], 0);
    repeat (10) tick();
    park(4);
    req(3'd4, 3'd0);
    park(1);
    chk("t4_bit1", park_location[1], 1);
    chk("t4_bit4b", park_location[4], 0);
    repeat (10) tick();
    // 5: six-slot instance rejects index 7 and ignores park_set of 6
    req6 = 1'b1; tok6 = 3'd7; pat6 = 3'd0;
    tick();
    chk("t5_err", err6, 1);
    chk("t5_noack", ack6, 0);
    ps6 = 1'b1; psi6 = 3'd6;
    tick();
    chk("t5_loc", loc6, 0);
    chk("t5_free", free6, 6);
    ps6 = 1'b1; psi6 = 3'd5;
    tick();
    chk("t5_set5", loc6, 6'h20);
    chk("t5_free5", free6, 5);
    req6 = 1'b1; tok6 = 3'd1; pat6 = 3'd4;
    tick();
    chk("t5_ack", ack6, 1);
    tick();
    chk("t5_gate", gate6, 1);
    chk("t5_clr", loc6, 0);
    chk("t5_locked", locked6, 0);
    // 6: reset aborts OPEN and LOCK immediately
    park(3);
    req(3'd3, 3'd0);
    tick(); tick();
    chk("t6_open", gate_open, 1);
    reset = 1'b1;
    #1;
    chk("t6_gate_drop", gate_open, 0);
    chk("t6_loc", park_location, 0);
    chk("t6_free", free_count, 8);
    model_reset();
    tick();
    reset = 1'b0;
    repeat (3) begin
      req(3'd2, 3'd0);
      tick();
    end
    chk("t6_lock", locked, 1);
    reset = 1'b1;
    #1;
    chk("t6_lock_drop", locked, 0);
    model_reset();
    tick();
    reset = 1'b0;
    // random traffic with occasional reset
    repeat (1500) begin
      reset = $urandom_range(0, 299) == 0;
      if (reset) model_reset();
      park_set = $urandom_range(0, 1) == 1;
      park_set_idx = W'($urandom_range(0, S - 1));
      exit_req = $urandom_range(0, 2) == 0;
      pattern = W'($urandom);
      token = W'($urandom);
      tick();
    end
    reset = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
